// File: rtl/data_proc_pipe.sv
// data_proc_pipe: two-stage valid/ready arithmetic pipeline.
// S1 captures operands and opcode; S2 computes the W+1-bit signed result,
// the overflow/saturation flag and maintains a running accumulator.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. Ready never depends on the matching valid in the same cycle;
// in_ready is derived only from registered occupancy and out_ready. Once
// out_valid is raised, c/ovf/out_valid stay stable until out_ready is seen.
module data_proc_pipe #(
    parameter int W   = 8,
    parameter int SAT = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [2:0]   op,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W:0]   c,
    output logic         ovf,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam logic [2:0] OP_PASS_A = 3'b000;
    localparam logic [2:0] OP_PASS_B = 3'b001;
    localparam logic [2:0] OP_ADD    = 3'b010;
    localparam logic [2:0] OP_SUB    = 3'b011;
    localparam logic [2:0] OP_ACC    = 3'b100;
    localparam logic [2:0] OP_LOAD   = 3'b101;
    localparam logic [2:0] OP_MAX    = 3'b110;
    localparam logic [2:0] OP_MIN    = 3'b111;

    // Saturation limits of the W+1-bit accumulator.
    localparam logic [W:0] ACC_MAX = {1'b0, {W{1'b1}}};
    localparam logic [W:0] ACC_MIN = {1'b1, {W{1'b0}}};

    // Stage 1 holding registers.
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic [2:0]   r_op;
    logic         r_s1_valid;

    // Running accumulator, touched only by OP_ACC / OP_LOAD.
    logic [W:0]   r_acc;

    // Stage enables and the S1->S2 move strobe.
    logic         w_en1;
    logic         w_en2;
    logic         w_s1_move;

    // Sign-extended operands and datapath results.
    logic [W:0]   w_a_ext;
    logic [W:0]   w_b_ext;
    logic [W+1:0] w_acc_sum;
    logic         w_acc_oflow;
    logic [W:0]   w_res;
    logic         w_ovf;
    logic [W:0]   w_acc_nxt;
    logic         w_acc_load;

    // S2 may take new data when it is empty or being drained this edge;
    // S1 may take new data when it is empty or moving into S2 this edge.
    assign w_en2     = !out_valid || out_ready;
    assign w_en1     = !r_s1_valid || w_en2;
    assign in_ready  = w_en1;
    assign w_s1_move = w_en2 && r_s1_valid;

    // All arithmetic is done on operands widened by one sign bit.
    assign w_a_ext = {r_a[W-1], r_a};
    assign w_b_ext = {r_b[W-1], r_b};

    // Accumulate with one guard bit so the true sum is always representable;
    // overflow of the W+1-bit result shows up as the two top bits differing.
    always_comb begin
        w_acc_sum   = {r_acc[W], r_acc} + {w_a_ext[W], w_a_ext};
        w_acc_oflow = w_acc_sum[W+1] ^ w_acc_sum[W];
    end

    // Result, flag and accumulator-next selection for the op held in S1.
    always_comb begin
        w_res      = '0;
        w_ovf      = 1'b0;
        w_acc_nxt  = r_acc;
        w_acc_load = 1'b0;
        case (r_op)
            OP_PASS_A: w_res = w_a_ext;
            OP_PASS_B: w_res = w_b_ext;
            OP_ADD:    w_res = w_a_ext + w_b_ext;
            OP_SUB:    w_res = w_a_ext - w_b_ext;
            OP_ACC: begin
                w_acc_load = 1'b1;
                w_ovf      = w_acc_oflow;
                if ((SAT != 0) && w_acc_oflow) begin
                    // Sign of the guard bit tells which rail was crossed.
                    w_acc_nxt = w_acc_sum[W+1] ? ACC_MIN : ACC_MAX;
                end else begin
                    w_acc_nxt = w_acc_sum[W:0];
                end
                w_res = w_acc_nxt;
            end
            OP_LOAD: begin
                w_acc_load = 1'b1;
                w_acc_nxt  = w_a_ext;
                w_res      = w_a_ext;
            end
            OP_MAX: w_res = ($signed(w_a_ext) >= $signed(w_b_ext)) ? w_a_ext : w_b_ext;
            OP_MIN: w_res = ($signed(w_a_ext) <= $signed(w_b_ext)) ? w_a_ext : w_b_ext;
            default: w_res = '0;
        endcase
    end

    // Stage 1: capture a new transaction whenever S1 is free to advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= '0;
        end else if (w_en1) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_a  <= a;
                r_b  <= b;
                r_op <= op;
            end
        end
    end

    // Stage 2: register result and flag; hold everything while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            c         <= '0;
            ovf       <= 1'b0;
        end else if (w_en2) begin
            out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                c   <= w_res;
                ovf <= w_ovf;
            end
        end
    end

    // Accumulator: updates only as an accumulate/load op enters S2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (w_s1_move && w_acc_load) begin
            r_acc <= w_acc_nxt;
        end
    end

endmodule

// File: doc/data_proc_pipe.md
DATA_PROC_PIPE -- requirements
Module: data_proc_pipe

Interface
REQ-001 SHALL have parameter W, default 8, operand width in bits (W >= 2).
REQ-002 SHALL have parameter SAT, default 0, accumulator mode: 0 = wrap, 1 = saturate.
REQ-003 SHALL have port clk, input, 1, rising-edge clock, the only clock.
REQ-004 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-005 SHALL have port a, input, W, signed operand A.
REQ-006 SHALL have port b, input, W, signed operand B.
REQ-007 SHALL have port op, input, 3, operation select, sampled with the operands.
REQ-008 SHALL have port in_valid, input, 1, input transaction offered.
REQ-009 SHALL have port in_ready, output, 1, block accepts input this cycle.
REQ-010 SHALL have port c, output, W+1, signed registered result.
REQ-011 SHALL have port ovf, output, 1, accumulator overflow or saturation flag, aligned with c.
REQ-012 SHALL have port out_valid, output, 1, c and ovf valid.
REQ-013 SHALL have port out_ready, input, 1, downstream accepts the result.

Function
REQ-014 SHALL accept an input transaction on a rising edge with in_valid=1 and in_ready=1; SHALL accept nothing otherwise.
REQ-015 SHALL deliver a result on a rising edge with out_valid=1 and out_ready=1.
REQ-016 SHALL be a two-stage pipeline: S1 registers a, b, op and s1_valid; S2 computes and registers c, ovf and out_valid.
REQ-017 SHALL set en2 = !out_valid | out_ready, en1 = !s1_valid | en2, and in_ready = en1, with no combinational path from in_valid to in_ready.
REQ-018 SHALL have a latency of exactly 2 cycles from acceptance to out_valid when there is no stall, and SHALL sustain 1 transaction per cycle while out_ready=1.
REQ-019 SHALL hold c, ovf and out_valid stable while out_valid=1 and out_ready=0, with S1 holding its contents if it is occupied.
REQ-020 SHALL sign-extend both operands to W+1 bits before any arithmetic.
REQ-021 SHALL compute per op:
- 000: c = sext(a)
- 001: c = sext(b)
- 010: c = sext(a) + sext(b)
- 011: c = sext(a) - sext(b)
- 100: acc = acc + sext(a); c = new acc
- 101: acc = sext(a); c = sext(a)
- 110: c = signed max(a, b)
- 111: c = signed min(a, b)
REQ-022 SHALL keep ops 000-011, 110 and 111 exact in W+1 bits, with ovf=0 for them.
REQ-023 SHALL hold the accumulator acc as a W+1-bit signed register, updated only when an op 100/101 transaction moves S1->S2 (en2 & s1_valid).
REQ-024 SHALL, for op 100 with SAT=0, wrap the sum modulo 2^(W+1) and set ovf=1 when the true sum lies outside [-2^W, 2^W-1].
REQ-025 SHALL, for op 100 with SAT=1, clamp the sum to -2^W or 2^W-1 and set ovf=1 when clamping occurred.
REQ-026 SHALL, for op 101, set ovf=0.
REQ-027 SHALL leave acc unchanged under ops other than 100/101, including while stalled.
REQ-028 SHALL, when out_valid and out_ready are both 1 while s1_valid=1, load S2 from S1 in the same edge with no bubble.
REQ-029 SHALL, when in_valid=0 while S2 drains, clear out_valid on the delivering edge.

Reset
REQ-030 SHALL, on rst_n low, immediately and asynchronously clear c, ovf, out_valid, s1_valid and acc to 0; in_ready SHALL read 1 during and after reset.
REQ-031 SHALL discard any in-flight transaction on mid-operation reset; the first post-reset op 100 SHALL accumulate from acc=0.
REQ-032 SHALL release from reset synchronously to clk on the first rising edge with rst_n=1.

Verification (W=8)
REQ-033 SHALL pass the op sweep: a=-128, b=127, ops 000..011,110,111 with out_ready=1 -> c = -128, 127, -1, -255, 127, -128 respectively, each 2 cycles after acceptance, ovf=0.
REQ-034 SHALL pass the wrap accumulate test (SAT=0): op101 a=127, then op100 a=127 twice, then op100 a=127 -> c = 127, 254, 381->-131 (ovf=1), then -4.
REQ-035 SHALL pass the saturating accumulate test (SAT=1): same stimulus as REQ-034 -> c = 127, 254, 255 (ovf=1), 255 (ovf=1); then op100 a=-128 -> 127, ovf=0.
REQ-036 SHALL pass the backpressure test: stream 6 op010 transactions, out_ready low for 3 cycles mid-stream -> c held stable, in_ready=0 once S1 and S2 are both full, all 6 results delivered in order, none lost or duplicated.
REQ-037 SHALL pass the reset test: assert rst_n low between clock edges with both stages full and acc=50 -> out_valid=0, c=0, acc=0 without waiting for an edge; first op100 a=3 after release -> c=3.
